// File: rtl/mux_scan_pkg.sv
// +------------------------------------------------------------------+
// | mux_scan_pkg : shared types, defaults and width helpers           |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

package mux_scan_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // A dwell of 1 still needs a 1-bit counter to keep the port legal.
  function automatic int cnt_width(input int dwell);
    return (clog2(dwell) < 1) ? 1 : clog2(dwell);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
// +------------------------------------------------------------------+
// | dwell_counter : counts 0..DWELL-1, tick on terminal count         |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// +------------------------------------------------------------------+
// | mux_scan_ctrl : drives a 16:1 mux through every select position   |
// |                 and reassembles the word seen on its output       |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] mux_a,
  output logic [SEL_W-1:0] mux_s,
  input  logic             mux_f,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] capture,
  output logic             match
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

  state_e           state;
  logic             tick;
  logic [WIDTH-1:0] cap_next;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != SCAN),
    .en   (state == SCAN),
    .tick (tick)
  );

  // Capture with the current sample merged, so match can be judged on the
  // same edge that takes the final sample and is valid alongside done.
  always_comb begin
    cap_next        = capture;
    cap_next[mux_s] = mux_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mux_a   <= '0;
      mux_s   <= '0;
      capture <= '0;
      match   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mux_a   <= din;
            capture <= '0;
            mux_s   <= '0;
            match   <= 1'b0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (tick) begin
            capture <= cap_next;
            if (mux_s == LAST_SEL) begin
              match <= (cap_next == mux_a);
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mux_s <= mux_s + SEL_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          mux_s <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// +------------------------------------------------------------------+
// | tb_mux_scan_ctrl : directed + random scans on DWELL=2 and DWELL=1 |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st = 1'b0;
  logic dsel = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] flip = '0;
  logic force0 = 1'b0;

  logic [15:0] a2, a1, cap2, cap1;
  logic [3:0]  s2, s1;
  logic        f2, f1, busy2, busy1, done2, done1, match2, match1;
  logic        start2, start1;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] prev_cap [2];
  logic        prev_match [2];

  always #5 clk = ~clk;

  // Mux model: a[s], optionally corrupted per position or stuck at 0.
  assign f2 = force0 ? 1'b0 : (a2[s2] ^ flip[s2]);
  assign f1 = force0 ? 1'b0 : (a1[s1] ^ flip[s1]);
  assign start2 = st & ~dsel;
  assign start1 = st & dsel;

  mux_scan_ctrl #(.WIDTH(16), .SEL_W(4), .DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din(din), .mux_a(a2), .mux_s(s2),
    .mux_f(f2), .busy(busy2), .done(done2), .capture(cap2), .match(match2)
  );

  mux_scan_ctrl #(.WIDTH(16), .SEL_W(4), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din), .mux_a(a1), .mux_s(s1),
    .mux_f(f1), .busy(busy1), .done(done1), .capture(cap1), .match(match1)
  );

  wire [15:0] a_m     = dsel ? a1 : a2;
  wire [15:0] cap_m   = dsel ? cap1 : cap2;
  wire [3:0]  s_m     = dsel ? s1 : s2;
  wire        busy_m  = dsel ? busy1 : busy2;
  wire        done_m  = dsel ? done1 : done2;
  wire        match_m = dsel ? match1 : match2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan; returns in the done cycle. busy_poke>0 re-raises start
  // with all-ones data at that cycle of the scan.
  task automatic run_scan(input bit which, input logic [15:0] d, input logic [15:0] fl,
                          input bit f0, input int busy_poke);
    int          steps;
    int          per;
    int          dones;
    logic [15:0] ecap;
    per   = which ? 1 : 2;
    steps = 16 * per;
    dsel  = which;
    @(posedge clk); #1;
    chk("idle_busy", busy_m, 0);
    chk("idle_sel", s_m, 0);
    chk("idle_done", done_m, 0);
    chk("idle_cap_hold", cap_m, prev_cap[which]);
    chk("idle_match_hold", match_m, prev_match[which]);
    din = d; flip = fl; force0 = f0; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0; din = 16'($urandom);
    chk("acc_busy", busy_m, 1);
    chk("acc_sel", s_m, 0);
    chk("acc_a", a_m, d);
    chk("acc_cap", cap_m, 0);
    chk("acc_match", match_m, 0);
    ecap  = f0 ? 16'h0000 : (d ^ fl);
    dones = 0;
    for (int k = 1; k <= steps; k++) begin
      if (k == busy_poke) begin st = 1'b1; din = 16'hFFFF; end
      else st = 1'b0;
      @(posedge clk); #1;
      if (done_m) dones++;
      chk("scan_sel", s_m, (k < steps) ? k / per : 15);
      chk("scan_done", done_m, (k == steps) ? 1 : 0);
      chk("scan_busy", busy_m, 1);
      chk("scan_a", a_m, d);
    end
    st = 1'b0;
    chk("done_count", dones, 1);
    chk("capture", cap_m, ecap);
    chk("match", match_m, (ecap == d) ? 1 : 0);
    prev_cap[which]   = ecap;
    prev_match[which] = (ecap == d);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] rf;
    prev_cap[0] = '0; prev_cap[1] = '0;
    prev_match[0] = 1'b0; prev_match[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      dsel = w[0]; #0;
      chk("rst_a", a_m, 0);
      chk("rst_sel", s_m, 0);
      chk("rst_cap", cap_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_match", match_m, 0);
    end
    rst = 1'b0;

    run_scan(0, 16'hAAAA, 16'h0000, 1'b0, 0);
    run_scan(0, 16'h5A5A, 16'h0000, 1'b1, 0);
    run_scan(0, 16'h5A5A, 16'h0000, 1'b0, 0);
    run_scan(0, 16'h1234, 16'h0000, 1'b0, 10);

    // Reset in the middle of a scan discards it.
    dsel = 1'b0;
    @(posedge clk); #1;
    din = 16'h0F0F; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy_m, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_a", a_m, 0);
    chk("mid_rst_sel", s_m, 0);
    chk("mid_rst_cap", cap_m, 0);
    chk("mid_rst_busy", busy_m, 0);
    chk("mid_rst_done", done_m, 0);
    chk("mid_rst_match", match_m, 0);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      chk("post_rst_done", done_m, 0);
    end
    prev_cap[0] = '0; prev_cap[1] = '0;
    prev_match[0] = 1'b0; prev_match[1] = 1'b0;
    run_scan(0, 16'hC3C3, 16'h0000, 1'b0, 0);

    // DWELL=1, back to back at the earliest accepted cycle.
    run_scan(1, 16'h0001, 16'h0000, 1'b0, 0);
    run_scan(1, 16'h8000, 16'h0000, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      rd = 16'($urandom);
      rf = ($urandom_range(0, 1) == 0) ? 16'h0000 : (16'h0001 << $urandom_range(0, 15));
      run_scan(r[0], rd, rf, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 16:1 multiplexer `sixtoone` and drives its data and select inputs. On a start request it presents a latched 16-bit word and steps the select through all 16 positions, holding each for a programmable dwell. It samples the mux output once per position and reassembles the word. At the end it pulses `done` and reports whether the captured word matches the word presented.

## Interface
Parameters:
- WIDTH, 16, number of mux data inputs; fixed power of two
- SEL_W, 4, select width; equals log2(WIDTH)
- DWELL, 2, clock cycles each select value is held; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- din  in  WIDTH  word to present to the mux
- mux_a  out  WIDTH  data bus to mux `a`; holds the latched din
- mux_s  out  SEL_W  select to mux `s`
- mux_f  in  1  mux output `f`
- busy  out  1  high while in SCAN or DONE
- done  out  1  one-cycle pulse at end of scan
- capture  out  WIDTH  reassembled word; capture[i] = mux_f sampled while mux_s == i
- match  out  1  (capture == mux_a); valid from the done pulse until the next accepted start

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: busy=0.
  - On start=1: latch din into mux_a, clear capture, mux_s=0, dwell_cnt=0, match=0, next state SCAN.
- SCAN: busy=1. dwell_cnt increments each cycle.
  - When dwell_cnt == DWELL-1: capture[mux_s] <= mux_f and dwell_cnt <= 0.
  - At the same edge: if mux_s == WIDTH-1 go to DONE, else mux_s <= mux_s+1.
- DONE: lasts one cycle. done=1, busy=1.
  - match register loads (capture == mux_a), using capture including the final sample.
  - Next state IDLE.
- After DONE: mux_s returns to 0. mux_a, capture and match hold until the next accepted start.
- start is ignored in SCAN and DONE. No queuing.
- din is ignored except at the accepting edge.
- mux_s never wraps inside a scan. It runs 0 to WIDTH-1 exactly once.
- Width rules:
  - dwell_cnt width is max(1, clog2(DWELL)).
  - The mux_s compare is against WIDTH-1 at SEL_W bits.
- Reset, at any time including mid-scan: state IDLE. mux_a=0, mux_s=0, capture=0, match=0, busy=0, done=0, dwell_cnt=0. A partial scan is discarded.

## Timing
- Start accepted at edge E0. SCAN occupies WIDTH*DWELL cycles, so the mux_s value for index i is valid from E0+i*DWELL to E0+(i+1)*DWELL.
- mux_f is sampled at the last edge of each dwell window. The mux is combinational, so DWELL=1 is legal.
- done is high in the cycle after edge E0+WIDTH*DWELL. With defaults this is 33 cycles after the start edge.
- The earliest next accepted start is at the edge that ends DONE+1, which is the first IDLE cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `mux_scan_pkg`:
  - state enum (IDLE, SCAN, DONE)
  - WIDTH/SEL_W defaults
  - a clog2 helper
- One sub-module: `dwell_counter`.
  - Counts 0..DWELL-1.
  - Ports: clk, rst, clr, en, tick (tick = terminal count while en).
  - The FSM uses tick to advance mux_s.
- The bench connects mux_a/mux_s/mux_f to a real `sixtoone` instance, or to a fault-injecting model.

## Test plan
- Nominal: din=16'hAAAA, DWELL=2, real mux → mux_s steps 0..15 every 2 cycles; done pulses 33 cycles after start; capture=16'hAAAA; match=1.
- Stuck fault: din=16'h5A5A, mux_f forced 0 → capture=16'h0000, match=0; a second run with the force released gives match=1.
- Start while busy: start pulsed with din=16'hFFFF at cycle 10 of a 16'h1234 scan → ignored; capture=16'h1234; exactly one done.
- Reset mid-scan: rst at cycle 12 → next cycle all outputs 0 and state IDLE; no done; a new start with 16'hC3C3 completes with match=1.
- DWELL=1 back-to-back: starts with 16'h0001, then 16'h8000 at the first IDLE cycle → each done 17 cycles after its start, both match=1, mux_s returns to 0 between scans.
